// File: rtl/a2disk_volume_sequencer.sv
// Apple II block-command sequencer: validates one command against the selected volume's
// state, then runs the rd/wr -> ack -> release handshake with firmware and reports a status code.
module a2disk_volume_sequencer #(
  parameter int                   TIMEOUT_W      = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_unit,
  input  logic [31:0] cmd_lba,
  input  logic [5:0]  cmd_blk_cnt,
  output logic        done,
  output logic [2:0]  status,
  output logic        busy,
  input  logic [1:0]  vol_ready,
  input  logic [1:0]  vol_mounted,
  input  logic [1:0]  vol_readonly,
  input  logic [31:0] vol_size0,
  input  logic [31:0] vol_size1,
  input  logic [1:0]  vol_ack,
  output logic [1:0]  vol_active,
  output logic [31:0] vol_lba,
  output logic [5:0]  vol_blk_cnt,
  output logic [1:0]  vol_rd,
  output logic [1:0]  vol_wr
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_REL   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [2:0] S_OK         = 3'd0;
  localparam logic [2:0] S_NOT_READY  = 3'd1;
  localparam logic [2:0] S_WRITE_PROT = 3'd2;
  localparam logic [2:0] S_RANGE      = 3'd3;
  localparam logic [2:0] S_TIMEOUT    = 3'd4;
  localparam logic [2:0] S_BAD_CNT    = 3'd5;

  // Timeout fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [TIMEOUT_W-1:0] LP_TMO_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

  logic [2:0]           r_state;
  logic                 r_write;
  logic                 r_unit;
  logic [31:0]          r_lba;
  logic [5:0]           r_cnt;
  logic [2:0]           r_status;
  logic [1:0]           r_active;
  logic [1:0]           r_rd;
  logic [1:0]           r_wr;
  logic [TIMEOUT_W-1:0] r_tmo;

  logic [1:0]           w_sel;
  logic                 w_ack;
  logic                 w_up;
  logic [31:0]          w_size;
  logic [32:0]          w_end;
  logic [2:0]           w_err;
  logic                 w_tmo_hit;
  logic [TIMEOUT_W-1:0] w_tmo_next;

  assign w_sel      = r_unit ? 2'b10 : 2'b01;
  assign w_ack      = vol_ack[r_unit];
  assign w_up       = vol_ready[r_unit] && vol_mounted[r_unit];
  assign w_size     = r_unit ? vol_size1 : vol_size0;
  assign w_end      = {1'b0, r_lba} + {27'd0, r_cnt};
  assign w_tmo_hit  = (TIMEOUT_CYCLES != '0) && (r_tmo >= LP_TMO_LAST);
  assign w_tmo_next = (r_tmo == {TIMEOUT_W{1'b1}}) ? r_tmo : r_tmo + TIMEOUT_W'(1);

  always_comb begin
    w_err = S_OK;
    if (r_cnt == 6'd0)
      w_err = S_BAD_CNT;
    else if (!w_up)
      w_err = S_NOT_READY;
    else if (r_write && vol_readonly[r_unit])
      w_err = S_WRITE_PROT;
    else if (w_end > {1'b0, w_size})
      w_err = S_RANGE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_write  <= 1'b0;
      r_unit   <= 1'b0;
      r_lba    <= 32'd0;
      r_cnt    <= 6'd0;
      r_status <= S_OK;
      r_active <= 2'b00;
      r_rd     <= 2'b00;
      r_wr     <= 2'b00;
      r_tmo    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_write <= cmd_write;
            r_unit  <= cmd_unit;
            r_lba   <= cmd_lba;
            r_cnt   <= cmd_blk_cnt;
            r_tmo   <= '0;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_tmo <= w_tmo_next;
          if (w_err != S_OK) begin
            r_status <= w_err;
            r_state  <= ST_DONE;
          end else if (w_tmo_hit) begin
            r_status <= S_TIMEOUT;
            r_state  <= ST_DONE;
          end else if (!w_ack) begin
            // A stale ack left over from a timed-out request holds us here.
            r_active <= w_sel;
            if (r_write)
              r_wr <= w_sel;
            else
              r_rd <= w_sel;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          r_tmo <= w_tmo_next;
          if (!w_up || w_tmo_hit) begin
            r_active <= 2'b00;
            r_rd     <= 2'b00;
            r_wr     <= 2'b00;
            r_status <= w_up ? S_TIMEOUT : S_NOT_READY;
            r_state  <= ST_DONE;
          end else if (w_ack) begin
            r_rd    <= 2'b00;
            r_wr    <= 2'b00;
            r_state <= ST_REL;
          end
        end
        ST_REL: begin
          r_tmo <= w_tmo_next;
          if (!w_ack) begin
            r_active <= 2'b00;
            r_status <= S_OK;
            r_state  <= ST_DONE;
          end else if (w_tmo_hit) begin
            r_active <= 2'b00;
            r_status <= S_TIMEOUT;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign status      = r_status;
  assign vol_active  = r_active;
  assign vol_rd      = r_rd;
  assign vol_wr      = r_wr;
  assign vol_lba     = r_lba;
  assign vol_blk_cnt = r_cnt;

endmodule

// File: tb/tb_a2disk_volume_sequencer.sv
// Directed bench for a2disk_volume_sequencer: vector table with a reactive firmware model,
// plus hand-written sequences for ack timing, timeout, stale ack, unmount and async reset.
module tb_a2disk_volume_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic        cmd_unit = 1'b0;
  logic [31:0] cmd_lba = 32'd0;
  logic [5:0]  cmd_blk_cnt = 6'd0;
  logic        done;
  logic [2:0]  status;
  logic        busy;
  logic [1:0]  vol_ready = 2'b00;
  logic [1:0]  vol_mounted = 2'b00;
  logic [1:0]  vol_readonly = 2'b00;
  logic [31:0] vol_size0 = 32'd0;
  logic [31:0] vol_size1 = 32'd0;
  logic [1:0]  vol_ack = 2'b00;
  logic [1:0]  vol_active;
  logic [31:0] vol_lba;
  logic [5:0]  vol_blk_cnt;
  logic [1:0]  vol_rd;
  logic [1:0]  vol_wr;

  int checks = 0;
  int errors = 0;

  a2disk_volume_sequencer #(.TIMEOUT_W(24), .TIMEOUT_CYCLES(24'd20)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_unit(cmd_unit),
    .cmd_lba(cmd_lba), .cmd_blk_cnt(cmd_blk_cnt),
    .done(done), .status(status), .busy(busy),
    .vol_ready(vol_ready), .vol_mounted(vol_mounted), .vol_readonly(vol_readonly),
    .vol_size0(vol_size0), .vol_size1(vol_size1), .vol_ack(vol_ack),
    .vol_active(vol_active), .vol_lba(vol_lba), .vol_blk_cnt(vol_blk_cnt),
    .vol_rd(vol_rd), .vol_wr(vol_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic        unit;
    logic [31:0] lba;
    logic [5:0]  cnt;
    logic [1:0]  ready;
    logic [1:0]  mounted;
    logic [1:0]  ro;
    logic [31:0] size0;
    logic [31:0] size1;
    logic [2:0]  exp_st;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the command for exactly one edge; caller guarantees cmd_ready.
  task automatic issue(input logic w, input logic u, input logic [31:0] lba, input logic [5:0] cnt);
    cmd_write   = w;
    cmd_unit    = u;
    cmd_lba     = lba;
    cmd_blk_cnt = cnt;
    cmd_valid   = 1'b1;
    tick();
    cmd_valid   = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0] sel, seen_rd, seen_wr, seen_act, rw_at1, exp_rd, exp_wr;
    int         done_c;
    logic [2:0] st_at_done;
    sel      = v.unit ? 2'b10 : 2'b01;
    exp_rd   = (v.exp_st == 3'd0 && !v.write) ? sel : 2'b00;
    exp_wr   = (v.exp_st == 3'd0 &&  v.write) ? sel : 2'b00;
    seen_rd  = 2'b00;
    seen_wr  = 2'b00;
    seen_act = 2'b00;
    rw_at1   = 2'b00;
    done_c   = -1;
    st_at_done = 3'd7;
    vol_ready    = v.ready;
    vol_mounted  = v.mounted;
    vol_readonly = v.ro;
    vol_size0    = v.size0;
    vol_size1    = v.size1;
    vol_ack      = ~sel;        // the unselected unit's ack must be ignored
    issue(v.write, v.unit, v.lba, v.cnt);
    chk($sformatf("v%0d lba", idx), vol_lba, v.lba);
    chk($sformatf("v%0d blk_cnt", idx), vol_blk_cnt, v.cnt);
    chk($sformatf("v%0d busy", idx), busy, 1'b1);
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      tick();
      seen_rd  |= vol_rd;
      seen_wr  |= vol_wr;
      seen_act |= vol_active;
      if (c == 1) rw_at1 = vol_rd | vol_wr;
      if (done) begin
        done_c     = c;
        st_at_done = status;
      end
      vol_ack[v.unit] = vol_rd[v.unit] | vol_wr[v.unit];
    end
    chk($sformatf("v%0d done_seen", idx), (done_c > 0), 1'b1);
    chk($sformatf("v%0d status", idx), st_at_done, v.exp_st);
    chk($sformatf("v%0d done_cycle", idx), done_c, (v.exp_st == 3'd0) ? 3 : 1);
    chk($sformatf("v%0d rw_at_cycle2", idx), rw_at1, exp_rd | exp_wr);
    chk($sformatf("v%0d seen_rd", idx), seen_rd, exp_rd);
    chk($sformatf("v%0d seen_wr", idx), seen_wr, exp_wr);
    chk($sformatf("v%0d seen_active", idx), seen_act, exp_rd | exp_wr);
    tick();
    chk($sformatf("v%0d ready_after", idx), {cmd_ready, done, status}, {1'b1, 1'b0, v.exp_st});
    vol_ack = 2'b00;
  endtask

  initial begin
    int done_c;

    //           wr    unit  lba            cnt    rdy    mnt    ro     size0   size1   st
    vecs[0]  = '{1'b0, 1'b0, 32'd10,        6'd1,  2'b11, 2'b11, 2'b00, 32'd1000, 32'd1000, 3'd0};
    vecs[1]  = '{1'b1, 1'b1, 32'd10,        6'd1,  2'b11, 2'b11, 2'b10, 32'd1000, 32'd1000, 3'd2};
    vecs[2]  = '{1'b0, 1'b0, 32'd99,        6'd1,  2'b11, 2'b11, 2'b00, 32'd100,  32'd100,  3'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'd99,        6'd2,  2'b11, 2'b11, 2'b00, 32'd100,  32'd100,  3'd3};
    vecs[4]  = '{1'b0, 1'b0, 32'hFFFFFFFF,  6'd1,  2'b11, 2'b11, 2'b00, 32'd100,  32'd100,  3'd3};
    vecs[5]  = '{1'b0, 1'b1, 32'd0,         6'd0,  2'b11, 2'b11, 2'b00, 32'd1000, 32'd1000, 3'd5};
    vecs[6]  = '{1'b0, 1'b1, 32'd5,         6'd1,  2'b11, 2'b01, 2'b00, 32'd1000, 32'd1000, 3'd1};
    vecs[7]  = '{1'b1, 1'b1, 32'd499,       6'd1,  2'b11, 2'b11, 2'b01, 32'd100,  32'd500,  3'd0};
    vecs[8]  = '{1'b0, 1'b0, 32'd5,         6'd1,  2'b10, 2'b11, 2'b00, 32'd1000, 32'd1000, 3'd1};
    vecs[9]  = '{1'b1, 1'b0, 32'd0,         6'd63, 2'b11, 2'b11, 2'b10, 32'd63,   32'd10,   3'd0};
    vecs[10] = '{1'b0, 1'b1, 32'd0,         6'd63, 2'b11, 2'b11, 2'b00, 32'd1000, 32'd62,   3'd3};
    vecs[11] = '{1'b1, 1'b0, 32'd0,         6'd0,  2'b11, 2'b10, 2'b01, 32'd1000, 32'd1000, 3'd5};
    vecs[12] = '{1'b1, 1'b1, 32'd0,         6'd1,  2'b01, 2'b11, 2'b10, 32'd1000, 32'd1000, 3'd1};

    #23;
    chk("reset outputs", {cmd_ready, done, busy, vol_active, vol_rd, vol_wr, status},
        {1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'd0});
    chk("reset lba/cnt", {vol_lba, vol_blk_cnt}, {32'd0, 6'd0});
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Read on unit 0 with slow firmware: ack 5 cycles after rd, released 3 cycles later.
    vol_ready = 2'b11; vol_mounted = 2'b11; vol_readonly = 2'b00;
    vol_size0 = 32'd1000; vol_size1 = 32'd1000; vol_ack = 2'b00;
    issue(1'b0, 1'b0, 32'd10, 6'd1);
    chk("A rd in check", vol_rd, 2'b00);
    tick();
    chk("A rd rise", {vol_rd, vol_active, vol_lba, vol_blk_cnt}, {2'b01, 2'b01, 32'd10, 6'd1});
    repeat (4) tick();
    chk("A rd held", {vol_rd, vol_wr}, {2'b01, 2'b00});
    vol_ack[0] = 1'b1;
    tick();
    chk("A rd drop on ack", {vol_rd, vol_active, done}, {2'b00, 2'b01, 1'b0});
    repeat (2) tick();
    chk("A active held", {vol_active, done}, {2'b01, 1'b0});
    vol_ack[0] = 1'b0;
    tick();
    chk("A done", {done, status, vol_active}, {1'b1, 3'd0, 2'b00});
    tick();
    chk("A idle", {done, cmd_ready, busy}, {1'b0, 1'b1, 1'b0});

    // No ack at all: timeout must end the request 20 cycles after accept.
    issue(1'b0, 1'b0, 32'd20, 6'd2);
    done_c = -1;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      tick();
      if (done) done_c = c;
    end
    chk("B timeout cycle", done_c, 20);
    chk("B timeout status", {status, vol_rd, vol_active}, {3'd4, 2'b00, 2'b00});
    tick();
    chk("B idle", cmd_ready, 1'b1);

    // Firmware acks late; the next command must wait for that ack to fall.
    vol_ack[0] = 1'b1;
    issue(1'b0, 1'b0, 32'd30, 6'd1);
    repeat (5) tick();
    chk("C held in check", {vol_rd, vol_active, busy, cmd_ready}, {2'b00, 2'b00, 1'b1, 1'b0});
    vol_ack[0] = 1'b0;
    tick();
    chk("C rd after ack low", vol_rd, 2'b01);
    vol_ack[0] = 1'b1;
    tick();
    chk("C rd drop", {vol_rd, vol_active}, {2'b00, 2'b01});
    vol_ack[0] = 1'b0;
    tick();
    chk("C done", {done, status}, {1'b1, 3'd0});
    tick();

    // Volume unmounted mid-request.
    issue(1'b0, 1'b0, 32'd40, 6'd1);
    tick();
    chk("D rd up", vol_rd, 2'b01);
    vol_mounted[0] = 1'b0;
    tick();
    chk("D unmount", {done, status, vol_rd, vol_active}, {1'b1, 3'd1, 2'b00, 2'b00});
    tick();
    vol_mounted[0] = 1'b1;

    // Async reset in REQ_WAIT drops everything without a clock edge.
    issue(1'b1, 1'b1, 32'd50, 6'd3);
    tick();
    chk("E wr up", {vol_wr, vol_active}, {2'b10, 2'b10});
    #2 reset = 1'b1;
    #1;
    chk("E async drop", {vol_wr, vol_rd, vol_active, done, busy}, {2'b00, 2'b00, 2'b00, 1'b0, 1'b0});
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("E after release", {cmd_ready, done, status, vol_lba}, {1'b1, 1'b0, 3'd0, 32'd0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/a2disk_volume_sequencer.md
Name: a2disk_volume_sequencer

Overview:
- Apple II-side request sequencer sitting directly upstream of the PicoSoC disk-volume peripheral.
- Accepts one block command at a time from the slot-card command decoder.
- Validates the command against the volume's ready, mounted, readonly and size state.
- Drives that volume's active/lba/blk_cnt/rd/wr request lines, runs the four-phase ack handshake with firmware, and returns a one-cycle completion with a status code.

Parameters:
- TIMEOUT_W, 24: width of the handshake timeout counter.
- TIMEOUT_CYCLES, 24'hFFFFFF: cycles allowed from request assertion to handshake completion. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_unit  in  1  volume select, 0 or 1.
- cmd_lba  in  32  starting block.
- cmd_blk_cnt  in  6  block count.
- done  out  1  one-cycle completion pulse.
- status  out  3  result code, valid when done=1 and held until the next done.
- busy  out  1  high whenever state is not IDLE.
- vol_ready  in  2  per-unit ready from firmware.
- vol_mounted  in  2  per-unit mounted.
- vol_readonly  in  2  per-unit readonly.
- vol_size0  in  32  unit 0 size in blocks.
- vol_size1  in  32  unit 1 size in blocks.
- vol_ack  in  2  per-unit ack from firmware.
- vol_active  out  2  per-unit request-in-progress.
- vol_lba  out  32  latched LBA, shared by both units.
- vol_blk_cnt  out  6  latched count, shared by both units.
- vol_rd  out  2  per-unit read request (level).
- vol_wr  out  2  per-unit write request (level).

Behaviour:
- Reset (async assert, sync release): state IDLE; status, vol_lba and vol_blk_cnt cleared to 0. Output values after reset:
  - cmd_ready = 1
  - done = 0
  - busy = 0
  - vol_active, vol_rd, vol_wr = 0
- Reset mid-operation drops rd/wr/active immediately, with no done pulse.
- Status codes: 0 OK, 1 NOT_READY, 2 WRITE_PROT, 3 RANGE, 4 TIMEOUT, 5 BAD_CNT.
- IDLE:
  - Accept when cmd_valid && cmd_ready.
  - Latch write, unit, lba and blk_cnt; vol_lba and vol_blk_cnt update on the accept edge.
  - Go to CHECK.
- CHECK (one cycle). Checks in priority order:
  - blk_cnt == 0 → BAD_CNT.
  - !ready[u] || !mounted[u] → NOT_READY.
  - write && readonly[u] → WRITE_PROT.
  - {1'b0,lba} + blk_cnt > {1'b0,size[u]} → RANGE. Use 33-bit arithmetic, no wrap.
  - vol_ack[u] still high (stale from a previous timeout) → stay in CHECK until it drops, counting toward timeout.
  - Any error → DONE with that code.
  - Otherwise → REQ_WAIT: set vol_active[u]=1 and vol_rd[u] or vol_wr[u]=1 on the same edge.
- Latency: rd/wr are first visible 2 cycles after the accept edge. An error produces done 2 cycles after accept.
- REQ_WAIT:
  - Hold rd/wr and active high.
  - On vol_ack[u]=1, clear rd/wr and go to REL_WAIT; active stays high.
  - If mounted[u] or ready[u] falls, clear rd/wr/active → DONE with NOT_READY.
- REL_WAIT:
  - On vol_ack[u]=0, clear active → DONE with OK.
- Timeout:
  - Counter clears on accept and increments in CHECK, REQ_WAIT and REL_WAIT.
  - When the count reaches TIMEOUT_CYCLES (nonzero), clear rd/wr/active → DONE with TIMEOUT.
  - Counter saturates and never wraps.
- DONE (one cycle): done=1, status registered; next state IDLE, cmd_ready=1 the following cycle.
- Only the selected unit's bits are ever set; the other unit's rd/wr/active stay 0 throughout.
- ack on the unselected unit is ignored.
- cmd_valid outside IDLE is ignored; the command is not queued.
- Back-to-back commands: minimum 1 idle cycle between done and the next accept, since cmd_ready is low during DONE.
- Ack already high at REQ_WAIT entry is impossible, because CHECK waits for it low first.

Test Plan:
- Read, unit 0:
  - Setup: ready=mounted=1, size=1000; cmd lba=10, cnt=1, write=0.
  - Stimulus: firmware acks 5 cycles after rd rises, then drops ack 3 cycles later.
  - Expect: vol_rd[0] high 2 cycles after accept; vol_lba=10, blk_cnt=1; rd drops the cycle after ack rises; active drops after ack falls; done with status 0.
- Write to readonly unit 1 (readonly=1, write=1) → no wr pulse, done 2 cycles after accept, status 2.
- Range boundary, size=100:
  - lba=99, cnt=1 → OK.
  - lba=99, cnt=2 → status 3.
  - lba=32'hFFFFFFFF, cnt=1 → status 3 (no wrap).
- cnt=0 → status 5. Unmounted unit → status 1. Both complete with no rd/wr activity.
- Timeout with TIMEOUT_CYCLES=20 and no ack:
  - Expect: rd/active drop and status 4 within 20 cycles of accept.
  - Then: ack raised late and a new command issued → CHECK waits until ack falls before asserting rd.
- Async reset asserted during REQ_WAIT:
  - Expect: rd/wr/active go low immediately without a clock, no done pulse, cmd_ready=1 after release.
  - Also: mounted dropping mid-request → status 1.
